sp_memory_wb_pipe: RTL and testbench

SP_MEMORY_WB_PIPE -- requirements
Module: sp_memory_wb_pipe

---
 rtl/sp_memory_pkg.sv | 9 +
 rtl/sp_memory.sv | 37 +++
 rtl/sp_memory_wb_pipe.sv | 137 +++++++++++++
 tb/tb_sp_memory_wb_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_memory_pkg.sv
// rtl/sp_memory_pkg.sv - shared state encoding and latency limits for the sp_memory family
package sp_memory_pkg;

  typedef enum logic {INIT, READY} sp_state_e;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 4;

endpackage

// File: rtl/sp_memory.sv
// rtl/sp_memory.sv - single-port byte-writable memory core, one-cycle registered read
module sp_memory #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter     TECHNOLOGY = "GENERIC"
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       be,
  input  logic [$clog2(DEPTH)-1:0] adr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  if (TECHNOLOGY != "GENERIC") begin : g_bad_tech
    $error("sp_memory: only the GENERIC technology model is available");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage carries no reset so it maps onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (cs && we) begin
      for (int b = 0; b < WIDTH/8; b++) begin
        if (be[b]) mem[adr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (cs && !we) rdata <= mem[adr];
  end

endmodule

// File: rtl/sp_memory_wb_pipe.sv
// rtl/sp_memory_wb_pipe.sv - Wishbone B4 pipelined slave around sp_memory, fixed response latency
// Define SP_MEMORY_WB_INIT_EN to zero-fill the memory after reset while stalling the bus.
module sp_memory_wb_pipe
  import sp_memory_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 1024,
  parameter     TECHNOLOGY   = "GENERIC",
  parameter int READ_LATENCY = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        adr_i,
  input  logic [WIDTH-1:0]   dat_i,
  input  logic [WIDTH/8-1:0] sel_i,
  input  logic               we_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  output logic [WIDTH-1:0]   dat_o,
  output logic               ack_o,
  output logic               err_o,
  output logic               stall_o
);

  localparam int AW = $clog2(WIDTH/8);
  localparam int IW = $clog2(DEPTH);

  if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_bad_rl
    $error("sp_memory_wb_pipe: READ_LATENCY must be within 1..4");
  end

  logic [31:0]             wadr;
  logic [IW-1:0]           idx;
  logic                    oor;
  logic                    accept;
  logic                    stall;
  logic                    init_wr;
  logic [IW-1:0]           init_adr;
  logic [READ_LATENCY-1:0] vld_sr;
  logic [READ_LATENCY-1:0] err_sr;
  logic                    core_cs;
  logic                    core_we;
  logic [WIDTH/8-1:0]      core_be;
  logic [IW-1:0]           core_adr;
  logic [WIDTH-1:0]        core_wdata;
  logic [WIDTH-1:0]        core_rdata;

  assign wadr   = adr_i >> AW;
  assign idx    = wadr[IW-1:0];
  assign oor    = (wadr >> IW) != 32'd0;
  assign accept = cyc_i && stb_i && !stall;

`ifdef SP_MEMORY_WB_INIT_EN
  sp_state_e     state;
  logic [IW-1:0] init_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= INIT;
      init_cnt <= '0;
      stall    <= 1'b1;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == IW'(DEPTH - 1)) begin
        state <= READY;
        stall <= 1'b0;
      end
    end
  end

  assign init_wr  = (state == INIT);
  assign init_adr = init_cnt;
`else
  assign stall    = 1'b0;
  assign init_wr  = 1'b0;
  assign init_adr = '0;
`endif

  assign stall_o = stall;

  // Out-of-range requests still occupy a response slot but never touch the core.
  assign core_cs    = init_wr || (accept && !oor);
  assign core_we    = init_wr || we_i;
  assign core_be    = init_wr ? '1 : sel_i;
  assign core_adr   = init_wr ? init_adr : idx;
  assign core_wdata = init_wr ? '0 : dat_i;

  sp_memory #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .TECHNOLOGY (TECHNOLOGY)
  ) u_core (
    .clk   (clk_i),
    .rst   (rst_i),
    .cs    (core_cs),
    .we    (core_we),
    .be    (core_be),
    .adr   (core_adr),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_sr <= '0;
      err_sr <= '0;
    end else if (!cyc_i) begin
      vld_sr <= '0;
      err_sr <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | READ_LATENCY'(accept);
      err_sr <= (err_sr << 1) | READ_LATENCY'(accept && oor);
    end
  end

  // Gating with cyc_i suppresses a response that lands in the cycle the master abandons.
  assign ack_o = vld_sr[READ_LATENCY-1] && !err_sr[READ_LATENCY-1] && cyc_i;
  assign err_o = vld_sr[READ_LATENCY-1] &&  err_sr[READ_LATENCY-1] && cyc_i;

  if (READ_LATENCY == 1) begin : g_no_pipe
    assign dat_o = core_rdata;
  end else begin : g_pipe
    logic [WIDTH-1:0] dpipe [READ_LATENCY-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < READ_LATENCY-1; i++) dpipe[i] <= '0;
      end else begin
        dpipe[0] <= core_rdata;
        for (int i = 1; i < READ_LATENCY-1; i++) dpipe[i] <= dpipe[i-1];
      end
    end

    assign dat_o = dpipe[READ_LATENCY-2];
  end

endmodule

// File: tb/tb_sp_memory_wb_pipe.sv
// tb/tb_sp_memory_wb_pipe.sv - bench for sp_memory_wb_pipe, follows SP_MEMORY_WB_INIT_EN when defined
module tb_sp_memory_wb_pipe;

  localparam int W  = 32;
  localparam int D  = 1024;
  localparam int RL = 2;
`ifdef SP_MEMORY_WB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   adr = '0;
  logic [W-1:0]  dat = '0;
  logic [W/8-1:0] sel = '0;
  logic          we  = 1'b0;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic [W-1:0]  dat_o;
  logic          ack_o, err_o, stall_o;

  sp_memory_wb_pipe #(
    .WIDTH(W), .DEPTH(D), .TECHNOLOGY("GENERIC"), .READ_LATENCY(RL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat), .sel_i(sel), .we_i(we),
    .cyc_i(cyc), .stb_i(stb), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .stall_o(stall_o)
  );

  initial forever #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: memory image plus a queue of responses, each due RL cycles after its accept.
  typedef struct {
    int          due;
    bit          err;
    bit          known;
    logic [31:0] data;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mmem [D];
  bit          mknown [D];
  int          cyc_cnt = 0;
  int          rel_cnt = 0;
  logic [31:0] got[$];
  int          n_err_seen = 0;

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 32'hxxxx_xxxx;
  endfunction

  initial forever begin : model
    bit    busy, oor;
    int    w;
    resp_t r;
    @(posedge clk);
    if (rst) begin
      q.delete();
      rel_cnt = 0;
    end else begin
      busy = INIT_EN && (rel_cnt < D);
      if (busy) begin
        mmem[rel_cnt]   = '0;
        mknown[rel_cnt] = 1'b1;
      end
      if (!cyc) begin
        q.delete();
      end else if (stb && !busy) begin
        oor     = (adr >> 12) != 0;
        w       = int'((adr >> 2) & (D - 1));
        r.due   = cyc_cnt + RL;
        r.err   = oor;
        r.known = 1'b0;
        r.data  = '0;
        if (!oor && !we) begin
          r.known = mknown[w];
          r.data  = mmem[w];
        end
        if (!oor && we) begin
          for (int b = 0; b < 4; b++)
            if (sel[b]) mmem[w][8*b +: 8] = dat[8*b +: 8];
          mknown[w] = mknown[w] || (sel == 4'hF);
        end
        q.push_back(r);
      end
      if (rel_cnt < D) rel_cnt++;
    end
    cyc_cnt++;
  end

  initial forever begin : compare
    bit          e_ack, e_err, e_stall, e_known;
    logic [31:0] e_dat;
    @(negedge clk);
    e_ack = 0; e_err = 0; e_known = 0; e_dat = '0;
    if (rst) begin
      q.delete();
      e_stall = INIT_EN;
    end else begin
      e_stall = INIT_EN && (rel_cnt < D);
      if (q.size() > 0 && q[0].due == cyc_cnt) begin
        if (cyc) begin
          e_ack   = !q[0].err;
          e_err   = q[0].err;
          e_known = q[0].known;
          e_dat   = q[0].data;
        end
        void'(q.pop_front());
      end
    end
    chk("ack_o", {31'd0, ack_o}, {31'd0, e_ack});
    chk("err_o", {31'd0, err_o}, {31'd0, e_err});
    chk("stall_o", {31'd0, stall_o}, {31'd0, e_stall});
    if (e_ack && e_known) chk("dat_o", dat_o, e_dat);
    if (ack_o) got.push_back(dat_o);
    if (err_o) n_err_seen++;
  end

  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    stb = 1'b0; we = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drop(input int n);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic stall_count(input string name);
    int c;
    c = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!stall_o) break;
      c++;
    end
    chk(name, c, INIT_EN ? D : 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin
    int e0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, {31'd0, INIT_EN});
    @(posedge clk); #1;
    rst = 1'b0;
    stall_count("init_stall_cycles");

`ifndef SP_MEMORY_WB_INIT_EN
    bus(1, 32'h0000_0FFC, 32'h0, 4'hF);
    idle(3);
`endif
    got.delete();
    bus(0, 32'h0000_0FFC, 32'h0, 4'h0);
    idle(4);
    chk("init_rd_cnt", got.size(), 1);
    chk("init_rd_data", got_at(0), 32'h0000_0000);

    bus(1, 32'h0, 32'hA5A5_0001, 4'hF);
    bus(1, 32'h4, 32'hA5A5_0002, 4'hF);
    bus(1, 32'h8, 32'hA5A5_0003, 4'hF);
    idle(3);
    got.delete();
    bus(0, 32'h0, 32'h0, 4'h0);
    bus(0, 32'h4, 32'h0, 4'h0);
    bus(0, 32'h8, 32'h0, 4'h0);
    idle(4);
    chk("b2b_cnt", got.size(), 3);
    chk("b2b_d0", got_at(0), 32'hA5A5_0001);
    chk("b2b_d1", got_at(1), 32'hA5A5_0002);
    chk("b2b_d2", got_at(2), 32'hA5A5_0003);

    bus(1, 32'h10, 32'h1122_3344, 4'hF);
    bus(1, 32'h10, 32'h0000_BB00, 4'b0010);
    idle(3);
    got.delete();
    bus(0, 32'h10, 32'h0, 4'h0);
    idle(4);
    chk("byte_wr", got_at(0), 32'h1122_BB44);

    e0 = n_err_seen;
    got.delete();
    bus(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    idle(4);
    chk("oor_err_cnt", n_err_seen - e0, 1);
    chk("oor_ack_cnt", got.size(), 0);
    bus(0, 32'h0, 32'h0, 4'h0);
    idle(4);
    chk("oor_word0", got_at(0), 32'hA5A5_0001);

    e0 = n_err_seen;
    got.delete();
    bus(0, 32'h4, 32'h0, 4'h0);
    bus(0, 32'h8, 32'h0, 4'h0);
    drop(4);
    chk("abort_ack_cnt", got.size(), 0);
    chk("abort_err_cnt", n_err_seen - e0, 0);
    bus(0, 32'h8, 32'h0, 4'h0);
    idle(4);
    chk("after_abort_cnt", got.size(), 1);
    chk("after_abort_data", got_at(0), 32'hA5A5_0003);
    drop(1);

    bus(0, 32'h0, 32'h0, 4'h0);
    bus(0, 32'h4, 32'h0, 4'h0);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("rst_burst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_burst_err", {31'd0, err_o}, 32'd0);
    @(posedge clk); #1;
    pulse_reset(1);
    stall_count("reinit_stall_cycles");

    repeat (100) begin @(posedge clk); #1; end
    pulse_reset(2);
    stall_count("midinit_stall_cycles");

    got.delete();
    bus(0, 32'h0, 32'h0, 4'h0);
    bus(0, 32'h10, 32'h0, 4'h0);
    idle(4);
    chk("final_word0", got_at(0), INIT_EN ? 32'h0 : 32'hA5A5_0001);
    chk("final_word4", got_at(1), INIT_EN ? 32'h0 : 32'h1122_BB44);
    drop(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
